// File: rtl/sel_encode_pkg.sv
// Shared defaults and the register-index width helper for the select/encode block.
package sel_encode_pkg;
    localparam int NREG_DEF   = 16;
    localparam int DATA_W_DEF = 32;
    localparam int IMM_W_DEF  = 18;
    localparam int RA_LSB_DEF = 23;
    localparam int RB_LSB_DEF = 19;
    localparam int RC_LSB_DEF = 15;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set wins over clear on the same index.
module reg_scoreboard
    import sel_encode_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int IW   = idx_w(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic [IW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [IW-1:0]   clr_idx,
    output logic [NREG-1:0] busy
);
    for (genvar i = 0; i < NREG; i++) begin : g_bit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                busy[i] <= 1'b0;
            else if (set_en && set_idx == IW'(i))
                busy[i] <= 1'b1;
            else if (clr_en && clr_idx == IW'(i))
                busy[i] <= 1'b0;
        end
    end
endmodule

// File: rtl/sel_encode_sb.sv
// Register-field select/encode with a pending-write scoreboard that blocks reads of busy registers.
module sel_encode_sb
    import sel_encode_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMM_W  = IMM_W_DEF,
    parameter int RA_LSB = RA_LSB_DEF,
    parameter int RB_LSB = RB_LSB_DEF,
    parameter int RC_LSB = RC_LSB_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ir_load,
    input  logic [DATA_W-1:0]        ir_in,
    input  logic                     gra,
    input  logic                     grb,
    input  logic                     grc,
    input  logic                     rin,
    input  logic                     rout,
    input  logic                     baout,
    input  logic                     wb_issue,
    input  logic                     wb_done,
    input  logic [idx_w(NREG)-1:0]   wb_idx,
    output logic [NREG-1:0]          reg_in,
    output logic [NREG-1:0]          reg_out,
    output logic                     zero_out,
    output logic [DATA_W-1:0]        c_sign_extended,
    output logic                     hazard,
    output logic [NREG-1:0]          busy
);
    localparam int IW = idx_w(NREG);

    logic [DATA_W-1:0] ir;
    logic [IW-1:0]     sel;
    logic [NREG-1:0]   onehot;
    logic              strobe, zero_case, rd_en, hz;

    assign strobe = gra | grb | grc;
    assign sel    = gra ? ir[RA_LSB +: IW] :
                    grb ? ir[RB_LSB +: IW] : ir[RC_LSB +: IW];
    assign onehot = {{(NREG-1){1'b0}}, 1'b1} << sel;

    // baout on R0 means "constant zero", which never touches the register file
    assign zero_case = strobe & baout & (sel == '0);
    assign rd_en     = strobe & (rout | baout) & ~zero_case;
    assign hz        = rd_en & busy[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir              <= '0;
            reg_in          <= '0;
            reg_out         <= '0;
            zero_out        <= 1'b0;
            c_sign_extended <= '0;
            hazard          <= 1'b0;
        end else begin
            if (ir_load) begin
                ir              <= ir_in;
                c_sign_extended <= {{(DATA_W-IMM_W){ir_in[IMM_W-1]}}, ir_in[IMM_W-1:0]};
            end
            reg_in   <= (strobe & rin) ? onehot : '0;
            reg_out  <= (rd_en & ~hz) ? onehot : '0;
            zero_out <= zero_case;
            hazard   <= hz;
        end
    end

    reg_scoreboard #(.NREG(NREG), .IW(IW)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (wb_issue & strobe),
        .set_idx (sel),
        .clr_en  (wb_done),
        .clr_idx (wb_idx),
        .busy    (busy)
    );
endmodule
